// File: rtl/axi_wr_back_rd_stream.sv
// Read-side drain engine for the write-back FIFO: issues pops, absorbs RAM read
// latency in a (RAM_LATENCY+1)-entry skid buffer, and drives a valid/ready stream.
module axi_wr_back_rd_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  fifo_rempty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level,
    output logic                  ovf_err
);

    localparam logic [1:0] DEPTH   = 2'(RAM_LATENCY + 1);
    localparam logic [2:0] DEPTH_W = 3'(RAM_LATENCY + 1);

    // Four slots so a 2-bit pointer indexes cleanly; only DEPTH of them are used.
    logic [DATA_WIDTH-1:0]  mem_q [4];
    logic [1:0]             head_q, head_d;
    logic [1:0]             tail_q, tail_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [RAM_LATENCY-1:0] inflight_q, inflight_d;
    logic                   ovf_q, ovf_d;
    logic                   rst_done_q;
    logic [2:0]             inflight_cnt;
    logic                   pop_out;
    logic                   tap;
    logic                   wr_en;
    logic                   wr_drop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == DEPTH - 2'd1) ? 2'd0 : p + 2'd1;
    endfunction

    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = mem_q[head_q];
    assign level   = cnt_q;
    assign ovf_err = ovf_q;
    assign pop_out = m_valid && m_ready;
    assign tap     = inflight_q[RAM_LATENCY-1];

    always_comb begin
        inflight_cnt = 3'd0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + 3'(inflight_q[i]);
        end
    end

    // Credit check written as cnt+inflight < D+pop to avoid an unsigned underflow.
    assign fifo_r_en = rst_done_q && !fifo_rempty && !clr &&
                       (({1'b0, cnt_q} + inflight_cnt) < (DEPTH_W + {2'b00, pop_out}));

    assign wr_en   = tap && !clr && ((cnt_q != DEPTH) || pop_out);
    assign wr_drop = tap && !clr && (cnt_q == DEPTH) && !pop_out;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q || wr_drop;
        inflight_d = RAM_LATENCY'({inflight_q, fifo_r_en});
        if (pop_out) begin
            head_d = next_ptr(head_q);
        end
        if (wr_en) begin
            tail_d = next_ptr(tail_q);
        end
        case ({wr_en, pop_out})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        // Flush drops buffered data and anything still returning from the RAM.
        if (clr) begin
            head_d     = 2'd0;
            tail_d     = 2'd0;
            cnt_d      = 2'd0;
            ovf_d      = 1'b0;
            inflight_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            cnt_q      <= 2'd0;
            ovf_q      <= 1'b0;
            inflight_q <= '0;
            rst_done_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            inflight_q <= inflight_d;
            rst_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[tail_q] <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_axi_wr_back_rd_stream.sv
// Bench for axi_wr_back_rd_stream: two instances (RAM latency 1 and 2) fed by a
// FIFO/RAM model; outputs are compared against the expected word order and timing.
module tb_axi_wr_back_rd_stream;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // instance 1: RAM_LATENCY = 1
    logic       clr1 = 1'b0, m_ready1 = 1'b0;
    logic       fifo_r_en1, m_valid1, ovf1, rempty1;
    logic [7:0] ram_rd1 = 8'h00, m_data1;
    logic [1:0] level1;
    int         total1 = 0, popped1 = 0;
    logic [7:0] src1 [1024];
    logic       pend1 = 1'b0;
    logic [7:0] got1 [$];
    int         bcyc1 [$];
    int         pops1 [$];

    // instance 2: RAM_LATENCY = 2
    logic       clr2 = 1'b0, m_ready2 = 1'b0;
    logic       fifo_r_en2, m_valid2, ovf2, rempty2;
    logic [7:0] ram_rd2 = 8'h00, st2 = 8'h00, m_data2;
    logic [1:0] level2;
    int         total2 = 0, popped2 = 0;
    logic [7:0] src2 [1024];
    logic       pend2 = 1'b0;
    logic [7:0] got2 [$];
    int         bcyc2 [$];
    int         pops2 [$];

    assign rempty1 = (popped1 >= total1);
    assign rempty2 = (popped2 >= total2);

    axi_wr_back_rd_stream #(.DATA_WIDTH(8), .RAM_LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .clr(clr1), .fifo_rempty(rempty1), .fifo_r_en(fifo_r_en1),
        .ram_rdata(ram_rd1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .level(level1), .ovf_err(ovf1)
    );

    axi_wr_back_rd_stream #(.DATA_WIDTH(8), .RAM_LATENCY(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .clr(clr2), .fifo_rempty(rempty2), .fifo_r_en(fifo_r_en2),
        .ram_rdata(ram_rd2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
        .level(level2), .ovf_err(ovf2)
    );

    function automatic logic [9:0] ix(input int v);
        return v[9:0];
    endfunction

    // FIFO + registered RAM model: a pop seen in a cycle yields its word RAM_LATENCY cycles later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pend1) begin
            ram_rd1 <= src1[ix(popped1)];
            popped1 <= popped1 + 1;
        end
        if (pend2) begin
            st2     <= src2[ix(popped2)];
            popped2 <= popped2 + 1;
        end
        ram_rd2 <= st2;
    end

    // Mid-cycle observer: records pops and accepted beats with their cycle numbers.
    always @(negedge clk) begin
        pend1 <= fifo_r_en1;
        pend2 <= fifo_r_en2;
        if (fifo_r_en1) pops1.push_back(cyc);
        if (fifo_r_en2) pops2.push_back(cyc);
        if (m_valid1 && m_ready1) begin
            got1.push_back(m_data1);
            bcyc1.push_back(cyc);
        end
        if (m_valid2 && m_ready2) begin
            got2.push_back(m_data2);
            bcyc2.push_back(cyc);
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int s;
        int base;
        rstn = 1'b0;
        m_ready1 = 1'b1;
        total1 = popped1 + 50;
        repeat (3) drive_edge();
        @(negedge clk);
        checks++; if (m_valid1 !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b expected 0", m_valid1); end
        checks++; if (fifo_r_en1 !== 1'b0) begin errors++; $display("FAIL rst_r_en got %0b expected 0", fifo_r_en1); end
        checks++; if (level1 !== 2'd0) begin errors++; $display("FAIL rst_level got %0d expected 0", level1); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b expected 0", ovf1); end
        checks++; if (m_data1 !== 8'h00) begin errors++; $display("FAIL rst_m_data got %0h expected 0", m_data1); end
        drive_edge();
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (fifo_r_en1 !== 1'b0) begin errors++; $display("FAIL rst_release_r_en got %0b expected 0", fifo_r_en1); end
        drive_edge();
        @(negedge clk);
        checks++; if (fifo_r_en1 !== 1'b1) begin errors++; $display("FAIL rst_first_r_en got %0b expected 1", fifo_r_en1); end
        drive_edge();
        total1 = popped1;
        base = popped1 - 1;
        s = got1.size();
        repeat (5) drive_edge();
        checks++;
        if (got1.size() != s + 1 || got1[s] !== src1[ix(base)]) begin
            errors++;
            $display("FAIL rst_first_word got count %0d expected 1", got1.size() - s);
        end
    endtask

    task automatic test_single();
        src1[ix(popped1)] = 8'hA5;
        m_ready1 = 1'b1;
        drive_edge();
        total1 = popped1 + 1;
        @(negedge clk);
        checks++; if (fifo_r_en1 !== 1'b1) begin errors++; $display("FAIL single_r_en got %0b expected 1", fifo_r_en1); end
        drive_edge();
        @(negedge clk);
        checks++; if (m_valid1 !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b expected 0", m_valid1); end
        drive_edge();
        @(negedge clk);
        checks++; if (m_valid1 !== 1'b1) begin errors++; $display("FAIL single_valid got %0b expected 1", m_valid1); end
        checks++; if (m_data1 !== 8'hA5) begin errors++; $display("FAIL single_data got %0h expected a5", m_data1); end
        checks++; if (level1 !== 2'd1) begin errors++; $display("FAIL single_level got %0d expected 1", level1); end
        drive_edge();
        @(negedge clk);
        checks++; if (m_valid1 !== 1'b0) begin errors++; $display("FAIL single_drained got %0b expected 0", m_valid1); end
        checks++; if (level1 !== 2'd0) begin errors++; $display("FAIL single_level_end got %0d expected 0", level1); end
    endtask

    task automatic test_stream();
        int base, s, sp, bad;
        base = popped1;
        for (int i = 0; i < 16; i++) src1[ix(base + i)] = 8'(i);
        s = got1.size();
        sp = pops1.size();
        m_ready1 = 1'b1;
        drive_edge();
        total1 += 16;
        repeat (24) drive_edge();
        checks++;
        if (pops1.size() - sp != 16 || pops1[sp + 15] - pops1[sp] != 15) begin
            errors++; $display("FAIL stream_pops got %0d pops expected 16 consecutive", pops1.size() - sp);
        end
        checks++;
        if (got1.size() - s != 16 || bcyc1[s + 15] - bcyc1[s] != 15) begin
            errors++; $display("FAIL stream_beats got %0d beats expected 16 consecutive", got1.size() - s);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (got1[s + i] !== 8'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_order got %0d wrong expected 0", bad); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL stream_ovf got %0b expected 0", ovf1); end
    endtask

    task automatic test_backpressure();
        int base, s, sp, bad;
        base = popped1;
        s = got1.size();
        sp = pops1.size();
        m_ready1 = 1'b0;
        drive_edge();
        total1 += 10;
        repeat (8) drive_edge();
        @(negedge clk);
        checks++; if (pops1.size() - sp != 2) begin errors++; $display("FAIL bp_pops got %0d expected 2", pops1.size() - sp); end
        checks++; if (fifo_r_en1 !== 1'b0) begin errors++; $display("FAIL bp_r_en got %0b expected 0", fifo_r_en1); end
        checks++; if (level1 !== 2'd2) begin errors++; $display("FAIL bp_level got %0d expected 2", level1); end
        checks++; if (m_data1 !== src1[ix(base)]) begin errors++; $display("FAIL bp_data got %0h expected %0h", m_data1, src1[ix(base)]); end
        repeat (5) drive_edge();
        @(negedge clk);
        checks++; if (m_valid1 !== 1'b1 || m_data1 !== src1[ix(base)]) begin
            errors++; $display("FAIL bp_stable got %0h expected %0h", m_data1, src1[ix(base)]);
        end
        drive_edge();
        m_ready1 = 1'b1;
        repeat (20) drive_edge();
        bad = 0;
        for (int i = 0; i < 10; i++) if (got1[s + i] !== src1[ix(base + i)]) bad++;
        checks++; if (got1.size() - s != 10 || bad != 0) begin
            errors++; $display("FAIL bp_release got %0d beats %0d wrong expected 10 beats 0 wrong", got1.size() - s, bad);
        end
        checks++; if (popped1 != total1) begin errors++; $display("FAIL bp_popped got %0d expected %0d", popped1, total1); end
    endtask

    task automatic test_random_ready();
        int base, s, bad, viol, maxl, budget;
        logic       prev_stall;
        logic [7:0] prev_data;
        base = popped1;
        s = got1.size();
        viol = 0; maxl = 0; budget = 0;
        prev_stall = 1'b0; prev_data = 8'h00;
        m_ready1 = 1'b0;
        drive_edge();
        total1 += 200;
        while (got1.size() - s < 200 && budget < 3000) begin
            @(negedge clk);
            if (int'(level1) > maxl) maxl = int'(level1);
            if (prev_stall && (!m_valid1 || m_data1 !== prev_data)) viol++;
            if (fifo_r_en1 && rempty1) viol++;
            prev_stall = m_valid1 && !m_ready1;
            prev_data = m_data1;
            drive_edge();
            m_ready1 = 1'($urandom_range(0, 1));
            budget++;
        end
        m_ready1 = 1'b1;
        checks++; if (got1.size() - s != 200) begin errors++; $display("FAIL rand_count got %0d expected 200", got1.size() - s); end
        bad = 0;
        for (int i = 0; i < 200; i++) if (got1[s + i] !== src1[ix(base + i)]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_order got %0d wrong expected 0", bad); end
        checks++; if (viol != 0) begin errors++; $display("FAIL rand_protocol got %0d violations expected 0", viol); end
        checks++; if (maxl > 2) begin errors++; $display("FAIL rand_max_level got %0d expected <=2", maxl); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL rand_ovf got %0b expected 0", ovf1); end
    endtask

    task automatic test_clr();
        int base0, base, s, bad;
        base0 = popped1;
        for (int i = 0; i < 8; i++) src1[ix(base0 + i)] = 8'(8'h30 + i);
        s = got1.size();
        m_ready1 = 1'b0;
        drive_edge();
        total1 = popped1 + 1;
        repeat (3) drive_edge();
        @(negedge clk);
        checks++; if (level1 !== 2'd1) begin errors++; $display("FAIL clr_pre_level got %0d expected 1", level1); end
        drive_edge();
        total1 = popped1 + 1;
        @(negedge clk);
        checks++; if (fifo_r_en1 !== 1'b1) begin errors++; $display("FAIL clr_pre_pop got %0b expected 1", fifo_r_en1); end
        drive_edge();
        clr1 = 1'b1;
        base = popped1;
        total1 = popped1 + 4;
        @(negedge clk);
        checks++; if (fifo_r_en1 !== 1'b0) begin errors++; $display("FAIL clr_r_en got %0b expected 0", fifo_r_en1); end
        drive_edge();
        clr1 = 1'b0;
        m_ready1 = 1'b1;
        @(negedge clk);
        checks++; if (m_valid1 !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b expected 0", m_valid1); end
        checks++; if (level1 !== 2'd0) begin errors++; $display("FAIL clr_level got %0d expected 0", level1); end
        repeat (12) drive_edge();
        bad = 0;
        for (int i = 0; i < 4; i++) if (got1[s + i] !== src1[ix(base + i)]) bad++;
        checks++; if (got1.size() - s != 4 || bad != 0) begin
            errors++; $display("FAIL clr_resume got %0d beats %0d wrong expected 4 beats 0 wrong", got1.size() - s, bad);
        end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b expected 0", ovf1); end
    endtask

    task automatic test_latency2();
        int base, s, sp, bad, maxl;
        base = popped2;
        s = got2.size();
        sp = pops2.size();
        maxl = 0;
        m_ready2 = 1'b1;
        drive_edge();
        total2 += 32;
        repeat (60) begin
            @(negedge clk);
            if (int'(level2) > maxl) maxl = int'(level2);
            drive_edge();
        end
        checks++;
        if (pops2.size() - sp != 32 || pops2[sp + 31] - pops2[sp] != 31) begin
            errors++; $display("FAIL lat2_pops got %0d pops expected 32 consecutive", pops2.size() - sp);
        end
        checks++;
        if (got2.size() - s != 32 || bcyc2[s + 31] - bcyc2[s] != 31) begin
            errors++; $display("FAIL lat2_beats got %0d beats expected 32 consecutive", got2.size() - s);
        end
        checks++; if (bcyc2[s] - pops2[sp] != 3) begin
            errors++; $display("FAIL lat2_latency got %0d expected 3", bcyc2[s] - pops2[sp]);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (got2[s + i] !== src2[ix(base + i)]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL lat2_order got %0d wrong expected 0", bad); end
        checks++; if (maxl > 3) begin errors++; $display("FAIL lat2_max_level got %0d expected <=3", maxl); end
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL lat2_ovf got %0b expected 0", ovf2); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            src1[i] = 8'($urandom);
            src2[i] = 8'($urandom);
        end
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random_ready();
        test_clr();
        test_latency2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
